bsg_frame_chan_credit_tx: RTL and testbench
===========================================

// Module: bsg_frame_chan_credit_tx
//
// PURPOSE
// Per-channel transmit credit stage between the frame core's outbound word stream and one
// output channel of the bsg_comm_link group. Buffers core words, gates launch on link
// calibration, and meters words against credits returned by the far end as token pulses,
// so the remote input FIFO can never overflow. One instance per output channel, 4 per chip.
//
// PARAMETERS
// width_p        8   channel word width (matches comm link channel_width)
// credits_p      16  remote FIFO depth in words; initial/maximum credit count
// decimation_p   4   words of credit returned per token pulse; must divide credits_p
//
// PORTS
// clk_i          in   1                      core clock
// reset_i        in   1                      synchronous, active-high reset
// calib_done_i   in   1                      link calibration finished (post-calib reset released)
// v_i            in   1                      core word valid
// data_i         in   width_p                core word
// ready_o        out  1                      stage accepts word (valid-then-ready handshake)
// token_i        in   1                      1-cycle pulse, clk_i-synchronous: decimation_p credits returned
// v_o            out  1                      word launched toward link this cycle (no backpressure)
// data_o         out  width_p                launched word
// credits_o      out  $clog2(credits_p+1)    current credit count
// overflow_o     out  1                      sticky: returned credits exceeded credits_p
//
// BEHAVIOUR
// - Reset: v_o=0, data_o=0, credits_o=credits_p, overflow_o=0, FIFO empty, state=WAIT_CALIB;
//   ready_o=0 while reset_i high.
// - Input: 2-entry FIFO; ready_o = ~full & ~reset_i; word accepted when v_i & ready_o.
// - FSM: WAIT_CALIB -> RUN when calib_done_i=1. RUN -> WAIT_CALIB when calib_done_i=0;
//   on that transition credits reload to credits_p (link recalibrated, remote FIFO empty).
// - Launch: send = (state==RUN) & calib_done_i & fifo_v & (credits!=0). On send, FIFO head is
//   dequeued and registered into v_o/data_o next cycle. v_o is high exactly 1 cycle per word.
//   data_o holds its last value when v_o=0.
// - Latency: word accepted in cycle N with FIFO empty and credits available -> v_o in N+2.
//   Sustained throughput 1 word/cycle.
// - Credits: next = cur - send + (token_i ? decimation_p : 0); send and token in the same
//   cycle both apply. If next > credits_p: saturate at credits_p, set overflow_o (cleared only by
//   reset). credits=0 -> no launch; token_i in WAIT_CALIB is ignored (credits stay credits_p).
// - calib_done_i falling mid-stream: no launch from that cycle; a word already registered
//   still appears on v_o; FIFO contents are retained; no word lost or duplicated.
// - Reset mid-operation: all state returns to reset values next edge; buffered words discarded.
// - Word order on data_o equals acceptance order on data_i.
//
// STRUCTURE
// - bsg_frame_pkg: FSM state enum (eWAIT_CALIB, eRUN), credit-width function.
// - Sub-module: bsg_two_fifo (width_p) for input buffering; credit counter, FSM and output
//   register live in this module.
//
// TESTING
// 1. Reset, calib_done_i=0, push 3 words -> ready_o low after 2 accepts, v_o=0, credits_o=16.
// 2. Raise calib_done_i, stream 20 words, no tokens -> exactly 16 v_o pulses in order,
//    credits_o=0, ready_o low with FIFO full.
// 3. From test 2, one token_i pulse -> credits_o 0->4, then exactly 4 more words launched.
// 4. credits_o=1, send and token_i in same cycle -> credits_o=4 next cycle, no overflow.
// 5. Idle at credits_o=16, pulse token_i once -> credits_o stays 16, overflow_o=1 until reset_i.
// 6. Stream data 0x00..0x1F with random tokens, drop calib_done_i for 5 cycles mid-stream ->
//    v_o stops within 1 cycle, credits_o reloads 16, output sequence complete and unduplicated.

Source files
------------

// File: rtl/bsg_frame_pkg.sv
// Shared types for the frame channel credit transmitter: FSM states and credit counter sizing.
package bsg_frame_pkg;

  typedef enum logic {
    eWAIT_CALIB = 1'b0,
    eRUN        = 1'b1
  } chan_state_e;

  // Counter must represent 0..credits inclusive.
  function automatic int credit_width(input int credits);
    return $clog2(credits + 1);
  endfunction

endpackage

// File: rtl/bsg_frame_chan_credit_tx_if.sv
// Valid-then-ready word stream from the frame core into one channel transmit stage.
interface bsg_frame_chan_credit_tx_if #(parameter int width_p = 8);
  logic               v;
  logic [width_p-1:0] data;
  logic               ready;

  modport master (output v, data, input  ready);
  modport slave  (input  v, data, output ready);
endinterface

// File: rtl/bsg_two_fifo.sv
// Two-entry FIFO; ready is simply ~full, so a full FIFO stalls one cycle before refilling.
module bsg_two_fifo #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [1:0][width_p-1:0] mem_q, mem_d;
  logic                    wptr_q, wptr_d;
  logic                    rptr_q, rptr_d;
  logic [1:0]              count_q, count_d;
  logic                    enq, deq;

  assign ready_o = (count_q != 2'd2);
  assign v_o     = (count_q != 2'd0);
  assign data_o  = mem_q[rptr_q];
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (enq) begin
      mem_d[wptr_q] = data_i;
      wptr_d        = ~wptr_q;
    end
    if (deq) rptr_d = ~rptr_q;
    count_d = count_q + {1'b0, enq} - {1'b0, deq};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk_i) mem_q <= mem_d;

endmodule

// File: rtl/bsg_frame_chan_credit_tx.sv
// Per-channel transmit stage: buffers core words, waits for link calibration, and meters
// launches against far-end credits returned as decimated token pulses.
module bsg_frame_chan_credit_tx
  import bsg_frame_pkg::*;
#(
  parameter  int width_p      = 8,
  parameter  int credits_p    = 16,
  parameter  int decimation_p = 4,
  localparam int cw_lp        = credit_width(credits_p)
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        calib_done_i,
  bsg_frame_chan_credit_tx_if.slave   core_i,
  input  logic                        token_i,
  output logic                        v_o,
  output logic [width_p-1:0]          data_o,
  output logic [cw_lp-1:0]            credits_o,
  output logic                        overflow_o
);

  localparam logic [cw_lp:0] max_lp = (cw_lp+1)'(credits_p);
  localparam logic [cw_lp:0] dec_lp = (cw_lp+1)'(decimation_p);

  chan_state_e        state_q, state_d;
  logic [cw_lp-1:0]   credits_q, credits_d;
  logic               overflow_q, overflow_d;
  logic               v_q, v_d;
  logic [width_p-1:0] data_q, data_d;

  logic               fifo_ready, fifo_v, send;
  logic [width_p-1:0] fifo_data;
  logic [cw_lp:0]     credit_sum;

  bsg_two_fifo #(.width_p(width_p)) fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (core_i.v),
    .data_i  (core_i.data),
    .ready_o (fifo_ready),
    .v_o     (fifo_v),
    .data_o  (fifo_data),
    .yumi_i  (send)
  );

  assign core_i.ready = fifo_ready & ~reset_i;
  assign send = (state_q == eRUN) & calib_done_i & fifo_v & (credits_q != '0);

  // One extra bit so a token on a nearly full count can be seen exceeding the max.
  assign credit_sum = {1'b0, credits_q} - {{cw_lp{1'b0}}, send}
                    + (token_i ? dec_lp : {(cw_lp+1){1'b0}});

  always_comb begin
    state_d    = state_q;
    credits_d  = credits_q;
    overflow_d = overflow_q;
    v_d        = send;
    data_d     = send ? fifo_data : data_q;
    case (state_q)
      eWAIT_CALIB: begin
        credits_d = max_lp[cw_lp-1:0];
        if (calib_done_i) state_d = eRUN;
      end
      eRUN: begin
        if (!calib_done_i) begin
          // Recalibration empties the remote FIFO, so the full allowance comes back.
          state_d   = eWAIT_CALIB;
          credits_d = max_lp[cw_lp-1:0];
        end else if (credit_sum > max_lp) begin
          credits_d  = max_lp[cw_lp-1:0];
          overflow_d = 1'b1;
        end else begin
          credits_d = credit_sum[cw_lp-1:0];
        end
      end
      default: state_d = eWAIT_CALIB;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= eWAIT_CALIB;
      credits_q  <= max_lp[cw_lp-1:0];
      overflow_q <= 1'b0;
      v_q        <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      credits_q  <= credits_d;
      overflow_q <= overflow_d;
      v_q        <= v_d;
      data_q     <= data_d;
    end
  end

  assign v_o        = v_q;
  assign data_o     = data_q;
  assign credits_o  = credits_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_bsg_frame_chan_credit_tx.sv
// Randomised self-checking bench for the channel credit transmitter.
module tb_bsg_frame_chan_credit_tx;

  localparam int W  = 8;
  localparam int CR = 16;
  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       reset_i, calib_done_i, token_i;
  logic       v_o, overflow_o;
  logic [W-1:0] data_o;
  logic [4:0] credits_o;

  bsg_frame_chan_credit_tx_if #(.width_p(W)) core_if ();

  bsg_frame_chan_credit_tx #(.width_p(W), .credits_p(CR), .decimation_p(DC)) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .calib_done_i (calib_done_i),
    .core_i       (core_if),
    .token_i      (token_i),
    .v_o          (v_o),
    .data_o       (data_o),
    .credits_o    (credits_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int next_word = 0;
  int launches = 0;
  logic [W-1:0] got[$];
  logic [W-1:0] acc[$];

  // Scoreboard capture mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (!reset_i) begin
      if (v_o) begin
        got.push_back(data_o);
        launches = launches + 1;
      end
      if (core_if.v && core_if.ready) acc.push_back(core_if.data);
    end
  end

  // One clock of stimulus; the source holds its word until it is accepted.
  task automatic step(input bit push, input bit tok);
    bit taken;
    core_if.v    = push;
    core_if.data = W'(next_word);
    token_i      = tok;
    #2;
    taken = push && core_if.ready;
    @(posedge clk); #1;
    token_i = 1'b0;
    if (taken) next_word++;
  endtask

  task automatic do_reset();
    reset_i = 1'b1; calib_done_i = 1'b0; core_if.v = 1'b0; token_i = 1'b0;
    step(0, 0);
    reset_i = 1'b0;
    got.delete(); acc.delete(); launches = 0; next_word = 0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1; calib_done_i = 1'b0; token_i = 1'b0;
    step(1, 0); step(1, 0);
    core_if.v = 1'b1;
    #1;
    checks++; if (core_if.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", core_if.ready); end
    checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL reset_v_o: got %b want 0", v_o); end
    checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data_o: got %h want 00", data_o); end
    checks++; if (credits_o !== 5'(CR)) begin errors++; $display("FAIL reset_credits: got %0d want %0d", credits_o, CR); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow_o); end
    checks++; if (next_word !== 0) begin errors++; $display("FAIL reset_accept: got %0d accepted want 0", next_word); end
    core_if.v = 1'b0;
    reset_i = 1'b0;
    got.delete(); acc.delete(); launches = 0; next_word = 0;
  endtask

  task automatic test_wait_calib();
    calib_done_i = 1'b0;
    for (int i = 0; i < 6; i++) step(1, 0);
    checks++; if (next_word !== 2) begin errors++; $display("FAIL calib_accepts: got %0d want 2", next_word); end
    checks++; if (core_if.ready !== 1'b0) begin errors++; $display("FAIL calib_ready: got %b want 0", core_if.ready); end
    checks++; if (launches !== 0) begin errors++; $display("FAIL calib_launch: got %0d want 0", launches); end
    checks++; if (credits_o !== 5'(CR)) begin errors++; $display("FAIL calib_credits: got %0d want %0d", credits_o, CR); end
  endtask

  task automatic test_credit_exhaust();
    calib_done_i = 1'b1;
    for (int i = 0; i < 40; i++) step(next_word < 20, 0);
    checks++; if (launches !== CR) begin errors++; $display("FAIL exhaust_launches: got %0d want %0d", launches, CR); end
    checks++; if (credits_o !== 5'd0) begin errors++; $display("FAIL exhaust_credits: got %0d want 0", credits_o); end
    checks++; if (core_if.ready !== 1'b0) begin errors++; $display("FAIL exhaust_ready: got %b want 0", core_if.ready); end
    checks++; if (next_word !== CR + 2) begin errors++; $display("FAIL exhaust_accepts: got %0d want %0d", next_word, CR + 2); end
    for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i] !== W'(i)) begin errors++; $display("FAIL exhaust_order[%0d]: got %h want %h", i, got[i], W'(i)); end
    end
  endtask

  task automatic test_token_refill();
    step(1, 1);
    checks++; if (credits_o !== 5'(DC)) begin errors++; $display("FAIL refill_credits: got %0d want %0d", credits_o, DC); end
    for (int i = 0; i < 15; i++) step(1, 0);
    checks++; if (launches !== CR + DC) begin errors++; $display("FAIL refill_launches: got %0d want %0d", launches, CR + DC); end
    checks++; if (credits_o !== 5'd0) begin errors++; $display("FAIL refill_drained: got %0d want 0", credits_o); end
    for (int i = CR; i < got.size(); i++) begin
      checks++; if (got[i] !== W'(i)) begin errors++; $display("FAIL refill_order[%0d]: got %h want %h", i, got[i], W'(i)); end
    end
  endtask

  task automatic test_send_and_token();
    int n;
    step(1, 1);
    n = 0;
    while (credits_o !== 5'd1 && n < 10) begin step(1, 0); n++; end
    checks++; if (credits_o !== 5'd1) begin errors++; $display("FAIL same_cycle_setup: got %0d want 1", credits_o); end
    step(1, 1);
    checks++; if (credits_o !== 5'(DC)) begin errors++; $display("FAIL same_cycle_credits: got %0d want %0d", credits_o, DC); end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL same_cycle_overflow: got %b want 0", overflow_o); end
    checks++; if (v_o !== 1'b1 || data_o !== W'(CR + 2 * DC - 1)) begin
      errors++; $display("FAIL same_cycle_launch: got v=%b d=%h want v=1 d=%h", v_o, data_o, W'(CR + 2 * DC - 1));
    end
  endtask

  task automatic test_overflow();
    do_reset();
    calib_done_i = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0);
    step(0, 1);
    checks++; if (credits_o !== 5'(CR)) begin errors++; $display("FAIL ovf_credits: got %0d want %0d", credits_o, CR); end
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow_o); end
    for (int i = 0; i < 5; i++) step(0, 0);
    checks++; if (overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow_o); end
    do_reset();
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", overflow_o); end
  endtask

  task automatic test_calib_drop();
    int base, toks, since_raise, cyc, ledger;
    bit dropped, tok;
    do_reset();
    calib_done_i = 1'b1;
    base = 0; toks = 0; since_raise = 0; cyc = 0; dropped = 1'b0;
    while (launches < 32 && cyc < 3000) begin
      if (!dropped && launches >= 12) begin
        dropped = 1'b1;
        calib_done_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
          step(next_word < 32 && $urandom_range(0, 3) != 0, 0);
          checks++; if (v_o !== 1'b0) begin errors++; $display("FAIL drop_v_o[%0d]: got %b want 0", i, v_o); end
          checks++; if (credits_o !== 5'(CR)) begin errors++; $display("FAIL drop_reload[%0d]: got %0d want %0d", i, credits_o, CR); end
        end
        calib_done_i = 1'b1;
        base = launches; toks = 0; since_raise = 0;
      end
      // Upper bound on the live credit count; tokens only when they cannot overflow.
      ledger = CR - (launches - base) + DC * toks;
      tok = (since_raise >= 2) && (ledger <= CR - DC) && ($urandom_range(0, 2) == 0);
      if (tok) toks++;
      step(next_word < 32 && $urandom_range(0, 3) != 0, tok);
      since_raise++; cyc++;
    end
    checks++; if (cyc >= 3000) begin errors++; $display("FAIL stream_timeout: got %0d launches want 32", launches); end
    for (int i = 0; i < 4; i++) step(0, 0);
    checks++; if (credits_o !== 5'(CR - (launches - base) + DC * toks)) begin
      errors++; $display("FAIL stream_credits: got %0d want %0d", credits_o, CR - (launches - base) + DC * toks);
    end
    checks++; if (overflow_o !== 1'b0) begin errors++; $display("FAIL stream_overflow: got %b want 0", overflow_o); end
    checks++; if (got.size() !== 32 || acc.size() !== 32) begin
      errors++; $display("FAIL stream_count: got %0d out %0d in want 32", got.size(), acc.size());
    end
    for (int i = 0; i < got.size() && i < acc.size(); i++) begin
      checks++; if (got[i] !== W'(i) || acc[i] !== W'(i)) begin
        errors++; $display("FAIL stream_order[%0d]: got out %h in %h want %h", i, got[i], acc[i], W'(i));
      end
    end
  endtask

  initial begin
    reset_i = 1'b1; calib_done_i = 1'b0; token_i = 1'b0;
    core_if.v = 1'b0; core_if.data = '0;
    test_reset();
    test_wait_calib();
    test_credit_exhaust();
    test_token_refill();
    test_send_and_token();
    test_overflow();
    test_calib_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
